// File: rtl/dac_wavegen_pkg.sv
// Shared definitions for the DAC waveform generator.
// - wave_e       : waveform select encoding carried on the config bus
// - DacMidscale  : unsigned DAC code for 0 V (output while disabled)
// - wave_value() : maps an 8-bit output phase to a DAC code
// - gen_sine_table() : builds the 256x8 sine ROM contents at elaboration time
package dac_wavegen_pkg;

  typedef enum logic [1:0] {
    WaveSquare = 2'd0,
    WaveSaw    = 2'd1,
    WaveTri    = 2'd2,
    WaveSine   = 2'd3
  } wave_e;

  localparam logic [7:0] DacMidscale = 8'h80;

  // Fixed-point precision for the elaboration-time sine evaluation.
  localparam int unsigned SineQ = 30;
  // round(pi * 2^SineQ)
  localparam longint PiQ = 64'sd3373259426;

  function automatic logic [7:0] wave_value(wave_e w, logic [7:0] p, logic [7:0] sine);
    logic [7:0] v;
    v = DacMidscale;
    unique case (w)
      WaveSquare: v = p[7] ? 8'h00 : 8'hFF;
      WaveSaw:    v = p;
      WaveTri:    v = p[7] ? {~p[6:0], 1'b0} : {p[6:0], 1'b0};
      WaveSine:   v = sine;
    endcase
    return v;
  endfunction

  // Entry p = round(127.5 + 127.5*sin(2*pi*p/256)), packed as byte p of the result.
  // Integer Taylor series on the first quadrant, mirrored; rounding is half-up so the
  // exact ties at p=0 and p=128 both give 0x80.
  function automatic logic [2047:0] gen_sine_table();
    logic [2047:0] tbl;
    longint        q;
    longint        x;
    longint        x2;
    longint        term;
    longint        sum;
    longint        scaled;
    longint        val;
    tbl = '0;
    for (int p = 0; p < 256; p++) begin
      q = longint'(p % 128);
      if (q > 64'sd64) q = 64'sd128 - q;
      x    = (PiQ * q) / 64'sd128;
      x2   = (x * x) >>> SineQ;
      term = x;
      sum  = x;
      for (longint n = 1; n <= 8; n++) begin
        term = -((term * x2) >>> SineQ) / ((64'sd2 * n) * (64'sd2 * n + 64'sd1));
        sum  = sum + term;
      end
      // 127.5*|sin| with SineQ+1 fractional bits
      scaled = 64'sd255 * sum;
      if (p < 128) begin
        val = 64'sd128 + (scaled >>> (SineQ + 1));
      end else begin
        val = 64'sd128 - ((scaled + (64'sd1 <<< (SineQ + 1)) - 64'sd1) >>> (SineQ + 1));
      end
      tbl[p*8 +: 8] = val[7:0];
    end
    return tbl;
  endfunction

endpackage

// File: rtl/dac_wavegen_if.sv
// Config handshake and DAC output bundle of the waveform generator.
// - master : config source / DAC consumer (drives cfg_*, observes outputs)
// - slave  : dac_wavegen itself
interface dac_wavegen_if #(
  parameter int unsigned PHASE_W = 24
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic               cfg_enable;
  logic [1:0]         cfg_wave;
  logic [PHASE_W-1:0] cfg_step;
  logic               dac_clk;
  logic [7:0]         dac_data;
  logic               sample_strobe;
  logic               sync;

  modport master (
    output cfg_valid, cfg_enable, cfg_wave, cfg_step,
    input  cfg_ready, dac_clk, dac_data, sample_strobe, sync
  );

  modport slave (
    input  cfg_valid, cfg_enable, cfg_wave, cfg_step,
    output cfg_ready, dac_clk, dac_data, sample_strobe, sync
  );
endinterface

// File: rtl/dac_wavegen_sine_rom.sv
// 256x8 sine lookup with one cycle of read latency.
// - iClk  : clock
// - iAddr : 8-bit output phase
// - oData : round(127.5 + 127.5*sin(2*pi*iAddr/256)), registered
module dac_wavegen_sine_rom
  import dac_wavegen_pkg::*;
(
  input  logic       iClk,
  input  logic [7:0] iAddr,
  output logic [7:0] oData
);
  localparam logic [2047:0] SineTable = gen_sine_table();

  always_ff @(posedge iClk) begin
    oData <= SineTable[{iAddr, 3'b000} +: 8];
  end
endmodule

// File: rtl/dac_wavegen.sv
// DDS waveform generator driving a parallel 8-bit DAC.
// - iClk, iRst : system clock, synchronous active-high reset
// - bus.cfg_*  : config word (enable, wave, step) with valid/ready handshake
// - bus.dac_clk, bus.dac_data : DAC sample clock (iClk/CLK_DIV) and sample
// - bus.sample_strobe : 1-cycle pulse when dac_data updates
// - bus.sync   : pulse with the strobe on the sample whose phase add wraps
// A new config is held pending and only takes over at a period boundary so the
// output stays phase-coherent.
module dac_wavegen
  import dac_wavegen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned PHASE_W = 24
) (
  input  logic iClk,
  input  logic iRst,
  dac_wavegen_if.slave bus
);
  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(CLK_DIV / 2 - 1);

  logic [DivW-1:0]    div_cnt_d, div_cnt_q;
  logic               strobe_d, strobe_q;
  logic               dac_clk_d, dac_clk_q;
  logic [7:0]         data_d, data_q;
  logic               sync_d, sync_q;
  logic [PHASE_W-1:0] phase_d, phase_q;

  logic               act_en_d, act_en_q;
  wave_e              act_wave_d, act_wave_q;
  logic [PHASE_W-1:0] act_step_d, act_step_q;

  logic               pend_valid_d, pend_valid_q;
  logic               pend_en_d, pend_en_q;
  wave_e              pend_wave_d, pend_wave_q;
  logic [PHASE_W-1:0] pend_step_d, pend_step_q;

  logic [PHASE_W-1:0] phase_sum;
  logic               carry;
  logic [7:0]         p_top;
  logic [7:0]         sine_data;
  logic               load;
  logic               accept;
  logic               apply;

  assign {carry, phase_sum} = {1'b0, phase_q} + {1'b0, act_step_q};
  assign p_top              = phase_q[PHASE_W-1 -: 8];

  // Output registers load on the last divider count so the new sample is visible
  // during the tick cycle (div_cnt==0); phase and config advance at the end of it.
  assign load   = (div_cnt_q == DivLast);
  assign accept = bus.cfg_valid & ~pend_valid_q;
  assign apply  = strobe_q & pend_valid_q & (carry | (act_step_q == '0) | ~act_en_q);

  // Phase is stable for CLK_DIV-1 cycles before each load, covering the ROM latency.
  dac_wavegen_sine_rom u_sine_rom (
    .iClk  (iClk),
    .iAddr (p_top),
    .oData (sine_data)
  );

  always_comb begin
    div_cnt_d    = load ? '0 : div_cnt_q + 1'b1;
    strobe_d     = load;
    dac_clk_d    = dac_clk_q;
    data_d       = data_q;
    sync_d       = 1'b0;
    phase_d      = phase_q;
    act_en_d     = act_en_q;
    act_wave_d   = act_wave_q;
    act_step_d   = act_step_q;
    pend_valid_d = pend_valid_q;
    pend_en_d    = pend_en_q;
    pend_wave_d  = pend_wave_q;
    pend_step_d  = pend_step_q;

    if (load) begin
      dac_clk_d = 1'b0;
    end else if (div_cnt_q == DivHalf) begin
      dac_clk_d = 1'b1;
    end

    if (load) begin
      data_d = act_en_q ? wave_value(act_wave_q, p_top, sine_data) : DacMidscale;
      sync_d = act_en_q & carry;
    end

    if (strobe_q) begin
      phase_d = act_en_q ? phase_sum : '0;
    end

    if (apply) begin
      act_en_d     = pend_en_q;
      act_wave_d   = pend_wave_q;
      act_step_d   = pend_step_q;
      pend_valid_d = 1'b0;
    end

    // accept needs pend_valid_q==0 and apply needs it ==1, so they never collide.
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_en_d    = bus.cfg_enable;
      pend_wave_d  = wave_e'(bus.cfg_wave);
      pend_step_d  = bus.cfg_step;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      div_cnt_q    <= '0;
      strobe_q     <= 1'b0;
      dac_clk_q    <= 1'b0;
      data_q       <= DacMidscale;
      sync_q       <= 1'b0;
      phase_q      <= '0;
      act_en_q     <= 1'b0;
      act_wave_q   <= WaveSquare;
      act_step_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_en_q    <= 1'b0;
      pend_wave_q  <= WaveSquare;
      pend_step_q  <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      strobe_q     <= strobe_d;
      dac_clk_q    <= dac_clk_d;
      data_q       <= data_d;
      sync_q       <= sync_d;
      phase_q      <= phase_d;
      act_en_q     <= act_en_d;
      act_wave_q   <= act_wave_d;
      act_step_q   <= act_step_d;
      pend_valid_q <= pend_valid_d;
      pend_en_q    <= pend_en_d;
      pend_wave_q  <= pend_wave_d;
      pend_step_q  <= pend_step_d;
    end
  end

  assign bus.cfg_ready     = ~pend_valid_q;
  assign bus.dac_clk       = dac_clk_q;
  assign bus.dac_data      = data_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.sync          = sync_q;

endmodule

// File: tb/tb_dac_wavegen.sv
// Bench for dac_wavegen: directed and random config sequences, every cycle compared
// against a sample-level reference model.
module tb_dac_wavegen;
  localparam int  ClkDiv = 4;
  localparam int  PhaseW = 24;
  localparam longint PhaseMod = 64'sd1 <<< PhaseW;

  logic clk;
  logic rst;

  dac_wavegen_if #(.PHASE_W(PhaseW)) bus ();

  dac_wavegen #(
    .CLK_DIV (ClkDiv),
    .PHASE_W (PhaseW)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference waveform straight from the formulas.
  function automatic int ref_wave(input int w, input int p);
    real s;
    case (w)
      0: return (p < 128) ? 255 : 0;
      1: return p;
      2: return (p < 128) ? 2 * p : 2 * (255 - p);
      default: begin
        s = 127.5 + 127.5 * $sin(2.0 * 3.141592653589793 * p / 256.0);
        return int'($floor(s + 0.5));
      end
    endcase
  endfunction

  // Model state: cycles since reset release, phase, active and pending config.
  bit     started = 0;
  longint m_cyc;
  longint m_phase;
  longint m_step;
  int     m_wave;
  bit     m_en;
  int     m_data;
  bit     m_sync;
  bit     m_pend;
  bit     mp_en;
  int     mp_wave;
  longint mp_step;
  bit     t_tick;
  bit     t_carry;
  bit     t_ready;
  bit     t_apply;

  always @(negedge clk) begin
    t_tick  = (m_cyc > 0) && (m_cyc % ClkDiv == 0);
    t_ready = !m_pend;
    t_carry = (m_phase + m_step) >= PhaseMod;
    if (started) begin
      m_sync = 1'b0;
      if (t_tick) begin
        m_data = m_en ? ref_wave(m_wave, int'(m_phase >> (PhaseW - 8))) : 128;
        m_sync = m_en && t_carry;
      end
      check("strobe", 32'(bus.sample_strobe), 32'(t_tick));
      check("dac_clk", 32'(bus.dac_clk), 32'((m_cyc % ClkDiv) >= ClkDiv / 2));
      check("cfg_ready", 32'(bus.cfg_ready), 32'(t_ready));
      check("dac_data", 32'(bus.dac_data), 32'(m_data));
      check("sync", 32'(bus.sync), 32'(m_sync));
    end
    if (rst) begin
      started = 1'b1;
      m_cyc   = 0;
      m_phase = 0;
      m_step  = 0;
      m_wave  = 0;
      m_en    = 1'b0;
      m_data  = 128;
      m_pend  = 1'b0;
    end else begin
      if (t_tick) begin
        t_apply = m_pend && (t_carry || m_step == 0 || !m_en);
        m_phase = m_en ? (m_phase + m_step) % PhaseMod : 0;
        if (t_apply) begin
          m_en   = mp_en;
          m_wave = mp_wave;
          m_step = mp_step;
          m_pend = 1'b0;
        end
      end
      if (bus.cfg_valid && t_ready) begin
        m_pend  = 1'b1;
        mp_en   = bus.cfg_enable;
        mp_wave = int'(bus.cfg_wave);
        mp_step = longint'(bus.cfg_step);
      end
      m_cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit en, input int w, input int unsigned st);
    int n;
    bit took;
    n    = 0;
    took = 1'b0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_enable = en;
    bus.cfg_wave   = 2'(w);
    bus.cfg_step   = PhaseW'(st);
    while (!took && n < 5000) begin
      @(negedge clk);
      took = bus.cfg_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cfg_valid = 1'b0;
    check("push_accept", 32'(took), 32'd1);
  endtask

  function automatic int unsigned rand_step();
    if ($urandom_range(0, 7) == 0) return 0;
    return $urandom_range(32'h20000, 32'hFFFFFF);
  endfunction

  // Keep valid high with junk words; the model decides whether any get accepted.
  task automatic hold_junk(input int n);
    repeat (n) begin
      bus.cfg_valid  = 1'b1;
      bus.cfg_enable = 1'($urandom_range(0, 1));
      bus.cfg_wave   = 2'($urandom_range(0, 3));
      bus.cfg_step   = PhaseW'(rand_step());
      @(posedge clk);
      #1;
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_sample(input int value);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < 3000) begin
      @(negedge clk);
      found = bus.sample_strobe && (int'(bus.dac_data) == value);
      n++;
    end
    @(posedge clk);
    #1;
    check("wait_sample", 32'(found), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_enable = 1'b0;
    bus.cfg_wave   = 2'd0;
    bus.cfg_step   = '0;
    idle(3);
    rst = 1'b0;
    idle(40);

    // Saw over a full period, then a coherent switch to square mid-period.
    push(1'b1, 1, 32'h010000);
    idle(1100);
    wait_sample(8'h40);
    push(1'b1, 0, 32'h010000);
    idle(900);

    push(1'b1, 2, 32'h400000);
    idle(60);
    push(1'b1, 3, 32'h400000);
    idle(60);

    // Step 0 and disabled configs are left at the very next tick.
    push(1'b1, 1, 32'h0);
    idle(20);
    push(1'b1, 2, 32'h400000);
    idle(40);
    push(1'b0, 1, 32'h100000);
    idle(30);
    push(1'b1, 3, 32'h200000);
    idle(40);

    for (int i = 0; i < 25; i++) begin
      push(($urandom_range(0, 5) != 0), $urandom_range(0, 3), rand_step());
      if ($urandom_range(0, 2) == 0) hold_junk($urandom_range(1, 12));
      idle($urandom_range(0, 400));
    end

    // Reset while a config is pending.
    push(1'b1, 1, 32'h020000);
    idle(30);
    push(1'b1, 3, 32'h020000);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(50);
    push(1'b1, 2, 32'h080000);
    idle(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
